pipe_ctrl: RTL and testbench

- Parametrised pipeline control unit for the in-order RV32I core.
- Replaces the fixed 4-stage warmup/stall/flush status machine inside the core top with a generic N-stage controller.
- Drives per-stage capture enables, bubble insertion, flush masks and PC update control.
- Adds an externally requested pause (debug/halt) with exact state resume, and a configurable load-use stall length.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the generic pipeline controller.
// Imported by pipe_ctrl and anything that decodes its debug state.
package pipe_ctrl_pkg;

    localparam int PIPE_STATE_W = 3;

    typedef enum logic [PIPE_STATE_W-1:0] {
        WARMUP,
        RUN,
        STALL,
        FLUSH,
        PAUSE
    } pipe_state_t;

    function automatic bit params_ok(
        input int n,
        input int h,
        input int b,
        input int l
    );
        return (n >= 3) && (n <= 8) &&
               (h > 0) && (h < b) && (b < n) &&
               (l >= 1) && (l <= 7);
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// N-stage pipeline controller: warmup, load-use stall, branch flush,
// and an external pause that resumes the exact interrupted context.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES        = 4,
    parameter int HAZARD_STAGE      = 1,
    parameter int BRANCH_STAGE      = 3,
    parameter int LOAD_STALL_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_hazard,
    input  logic                    br_taken,
    input  logic                    pause_req,
    output logic [NUM_STAGES-1:0]   stage_en,
    output logic [NUM_STAGES-1:0]   bubble,
    output logic [NUM_STAGES-1:0]   flush,
    output logic                    pc_en,
    output logic                    pc_redirect,
    output logic                    paused,
    output logic [PIPE_STATE_W-1:0] state
);

    localparam int FW = $clog2(NUM_STAGES);
    localparam bit PARAMS_OK = params_ok(NUM_STAGES, HAZARD_STAGE,
                                         BRANCH_STAGE, LOAD_STALL_CYCLES);

    if (!PARAMS_OK) begin : g_bad_params
        $error("pipe_ctrl: illegal parameter combination");
    end

    pipe_state_t   cur_q, nxt;
    logic [FW-1:0] fill_q, fill_d;
    logic [2:0]    stall_q, stall_d;
    pipe_state_t   sav_st_q, sav_st_d;
    logic [FW-1:0] sav_fill_q, sav_fill_d;
    logic [2:0]    sav_stall_q, sav_stall_d;
    logic          hz_take;

    assign state = cur_q;

    // State, counters and pause context; reset clears the saved context.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q       <= WARMUP;
            fill_q      <= '0;
            stall_q     <= '0;
            sav_st_q    <= WARMUP;
            sav_fill_q  <= '0;
            sav_stall_q <= '0;
        end else begin
            cur_q       <= nxt;
            fill_q      <= fill_d;
            stall_q     <= stall_d;
            sav_st_q    <= sav_st_d;
            sav_fill_q  <= sav_fill_d;
            sav_stall_q <= sav_stall_d;
        end
    end

    // Next state and per-stage controls; branch > hazard > pause > progress.
    always_comb begin
        nxt         = cur_q;
        fill_d      = fill_q;
        stall_d     = stall_q;
        sav_st_d    = sav_st_q;
        sav_fill_d  = sav_fill_q;
        sav_stall_d = sav_stall_q;
        stage_en    = '0;
        bubble      = '0;
        flush       = '0;
        pc_en       = 1'b0;
        pc_redirect = 1'b0;
        paused      = 1'b0;
        hz_take     = load_hazard &&
                      (cur_q == RUN ||
                       (cur_q == WARMUP &&
                        fill_q >= FW'(HAZARD_STAGE)));

        if (cur_q == PAUSE) begin
            paused = 1'b1;
            if (!pause_req) begin
                nxt     = sav_st_q;
                fill_d  = sav_fill_q;
                stall_d = sav_stall_q;
            end
        end else if (br_taken) begin
            pc_en       = 1'b1;
            pc_redirect = 1'b1;
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (i < BRANCH_STAGE) flush[i] = 1'b1;
                else                  stage_en[i] = 1'b1;
            end
            nxt     = FLUSH;
            fill_d  = '0;
            stall_d = '0;
        end else begin
            unique case (cur_q)
                WARMUP: begin
                    pc_en = 1'b1;
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        stage_en[i] = (FW'(i) <= fill_q);
                    end
                    if (fill_q == FW'(NUM_STAGES - 2)) begin
                        nxt    = RUN;
                        fill_d = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                RUN: begin
                    pc_en    = 1'b1;
                    stage_en = '1;
                end
                STALL: begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        stage_en[i] = (i > HAZARD_STAGE);
                    end
                    bubble[HAZARD_STAGE+1] = 1'b1;
                    if (stall_q == 3'd0) nxt = RUN;
                    else                 stall_d = stall_q - 1'b1;
                end
                FLUSH: begin
                    pc_en  = 1'b1;
                    nxt    = WARMUP;
                    fill_d = '0;
                end
                default: ;
            endcase

            if (hz_take) begin
                pc_en = 1'b0;
                for (int i = 0; i < NUM_STAGES; i++) begin
                    stage_en[i] = (i > HAZARD_STAGE);
                end
                bubble[HAZARD_STAGE+1] = 1'b1;
                nxt     = STALL;
                stall_d = 3'(LOAD_STALL_CYCLES - 1);
            end else if (pause_req && !load_hazard) begin
                // Park the untouched current context; resume replays it.
                sav_st_d    = cur_q;
                sav_fill_d  = fill_q;
                sav_stall_d = stall_q;
                nxt         = PAUSE;
                fill_d      = fill_q;
                stall_d     = stall_q;
            end
        end

        if (!rst) begin
            stage_en    = '0;
            bubble      = '0;
            flush       = '0;
            pc_en       = 1'b0;
            pc_redirect = 1'b0;
            paused      = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench: two controller configurations share one random
// stimulus stream and are checked against a cycle-level reference model.
module tb_pipe_ctrl;

    typedef struct packed {
        int n;
        int h;
        int b;
        int l;
    } cfg_t;

    typedef struct packed {
        int mode;
        int w;
        int left;
        int sv_mode;
        int sv_w;
        int sv_left;
    } ms_t;

    typedef struct packed {
        logic [7:0] en;
        logic [7:0] bub;
        logic [7:0] fl;
        logic       pc;
        logic       rd;
        logic       pz;
        logic [2:0] st;
    } exp_t;

    localparam int M_WARM  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STALL = 2;
    localparam int M_FLUSH = 3;
    localparam int M_PAUSE = 4;

    localparam cfg_t C0 = '{n: 4, h: 1, b: 3, l: 2};
    localparam cfg_t C1 = '{n: 6, h: 2, b: 5, l: 3};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic load_hazard = 1'b0;
    logic br_taken = 1'b0;
    logic pause_req = 1'b0;

    logic [3:0] en0, bub0, fl0;
    logic       pc0, rd0, pz0;
    logic [2:0] st0;
    logic [5:0] en1, bub1, fl1;
    logic       pc1, rd1, pz1;
    logic [2:0] st1;

    int   n_vec = 0;
    int   n_err = 0;
    ms_t  m0, m1;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    pipe_ctrl #(
        .NUM_STAGES(4), .HAZARD_STAGE(1),
        .BRANCH_STAGE(3), .LOAD_STALL_CYCLES(2)
    ) dut0 (
        .clk(clk), .rst(rst),
        .load_hazard(load_hazard), .br_taken(br_taken),
        .pause_req(pause_req),
        .stage_en(en0), .bubble(bub0), .flush(fl0),
        .pc_en(pc0), .pc_redirect(rd0),
        .paused(pz0), .state(st0)
    );

    pipe_ctrl #(
        .NUM_STAGES(6), .HAZARD_STAGE(2),
        .BRANCH_STAGE(5), .LOAD_STALL_CYCLES(3)
    ) dut1 (
        .clk(clk), .rst(rst),
        .load_hazard(load_hazard), .br_taken(br_taken),
        .pause_req(pause_req),
        .stage_en(en1), .bubble(bub1), .flush(fl1),
        .pc_en(pc1), .pc_redirect(rd1),
        .paused(pz1), .state(st1)
    );

    function automatic ms_t reset_ms();
        ms_t s;
        s = '{M_WARM, 0, 0, M_WARM, 0, 0};
        return s;
    endfunction

    // Reference: 'left' counts remaining STALL-state cycles, 'w' the
    // number of warmup cycles already spent.
    function automatic exp_t model(input cfg_t c, inout ms_t s,
                                   input logic r, input logic bt,
                                   input logic lh, input logic pr);
        exp_t e;
        ms_t  nx;
        int   full;
        int   hold;
        bit   can_hz;
        e    = '0;
        full = (1 << c.n) - 1;
        hold = full & ~((1 << (c.h + 1)) - 1);
        if (!r) begin
            s = reset_ms();
            return e;
        end
        nx   = s;
        e.st = 3'(s.mode);
        if (s.mode == M_PAUSE) begin
            e.pz = 1'b1;
            if (!pr) begin
                nx.mode = s.sv_mode;
                nx.w    = s.sv_w;
                nx.left = s.sv_left;
            end
        end else if (bt) begin
            e.pc    = 1'b1;
            e.rd    = 1'b1;
            e.fl    = 8'((1 << c.b) - 1);
            e.en    = 8'(full & ~((1 << c.b) - 1));
            nx.mode = M_FLUSH;
        end else begin
            can_hz = lh && (s.mode == M_RUN ||
                            (s.mode == M_WARM && s.w >= c.h));
            case (s.mode)
                M_WARM: begin
                    e.en = 8'((1 << (s.w + 1)) - 1);
                    e.pc = 1'b1;
                    nx.w = s.w + 1;
                    if (s.w + 1 == c.n - 1) nx.mode = M_RUN;
                end
                M_RUN: begin
                    e.en = 8'(full);
                    e.pc = 1'b1;
                end
                M_STALL: begin
                    e.en    = 8'(hold);
                    e.bub   = 8'(1 << (c.h + 1));
                    nx.left = s.left - 1;
                    if (nx.left == 0) nx.mode = M_RUN;
                end
                default: begin
                    e.pc    = 1'b1;
                    nx.mode = M_WARM;
                    nx.w    = 0;
                end
            endcase
            if (can_hz) begin
                e.en    = 8'(hold);
                e.bub   = 8'(1 << (c.h + 1));
                e.pc    = 1'b0;
                nx.mode = M_STALL;
                nx.left = c.l;
            end else if (pr && !lh) begin
                nx         = s;
                nx.mode    = M_PAUSE;
                nx.sv_mode = s.mode;
                nx.sv_w    = s.w;
                nx.sv_left = s.left;
            end
        end
        s = nx;
        return e;
    endfunction

    task automatic cyc(input logic r, input logic bt,
                       input logic lh, input logic pr);
        @(posedge clk);
        #1;
        rst         = r;
        br_taken    = bt;
        load_hazard = lh;
        pause_req   = pr;
        q0.push_back(model(C0, m0, r, bt, lh, pr));
        q1.push_back(model(C1, m1, r, bt, lh, pr));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input exp_t want,
                       input exp_t got);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s t=%0t got en=%b bub=%b fl=%b pc=%b rd=%b pz=%b st=%0d want en=%b bub=%b fl=%b pc=%b rd=%b pz=%b st=%0d",
                     nm, $time,
                     got.en, got.bub, got.fl, got.pc, got.rd,
                     got.pz, got.st,
                     want.en, want.bub, want.fl, want.pc, want.rd,
                     want.pz, want.st);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    always @(negedge clk) begin
        exp_t g;
        if (q0.size() > 0) begin
            g = '{8'(en0), 8'(bub0), 8'(fl0), pc0, rd0, pz0, st0};
            chk("dut4", q0.pop_front(), g);
        end
        if (q1.size() > 0) begin
            g = '{8'(en1), 8'(bub1), 8'(fl1), pc1, rd1, pz1, st1};
            chk("dut6", q1.pop_front(), g);
        end
    end

    initial begin
        logic bt, lh, pr, r;
        m0 = reset_ms();
        m1 = reset_ms();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        idle(7);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle(6);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(8);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        idle(8);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        idle(6);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle(8);

        pr = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            bt = ($urandom_range(0, 9) == 0);
            lh = ($urandom_range(0, 5) == 0);
            r  = ($urandom_range(0, 299) != 0);
            if (pr) pr = ($urandom_range(0, 3) != 0);
            else    pr = ($urandom_range(0, 19) == 0);
            cyc(r, bt, lh, pr);
        end

        @(negedge clk);
        #1;
        n_vec++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0",
                     q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
